xheep2bridge_obi_resp: RTL and testbench

OBI responder (slave) that lets X-HEEP write results into, and read words from, a small mailbox register bank, which the CW305 host reads and writes through a simple side port. It is the return path of the CW305↔X-HEEP bridge. The bridge's write path acts as the OBI initiator; this block sits on the X-HEEP system bus as the responding peripheral. A sticky doorbell flag tells the host that results are ready.

---
 rtl/bridge_pkg.sv | 22 ++
 rtl/bridge_mbox_regfile.sv | 39 +++
 rtl/xheep2bridge_obi_resp.sv | 170 +++++++++++++++++
 tb/tb_xheep2bridge_obi_resp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CW305 <-> X-HEEP bridge.
package bridge_pkg;

   localparam int unsigned OBI_ADDR_W = 32;
   localparam int unsigned OBI_DATA_W = 32;
   localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

   localparam logic [OBI_ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h2000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RESP = 2'd1,
      S_HOST = 2'd2
   } resp_state_e;

   // Host command captured when the host is accepted during an OBI response cycle.
   typedef struct packed {
      logic                  we;
      logic [OBI_DATA_W-1:0] wdata;
   } host_cmd_t;

endpackage

// File: rtl/bridge_mbox_regfile.sv
// Mailbox register bank: one byte-enabled write port, two combinational read ports.
module bridge_mbox_regfile
   import bridge_pkg::*;
#(
   parameter  int unsigned NUM_WORDS = 8,
   localparam int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [OBI_BE_W-1:0]   wr_be,
   input  logic [OBI_DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_a_idx,
   output logic [OBI_DATA_W-1:0] rd_a_data,
   input  logic [IDX_W-1:0]      rd_b_idx,
   output logic [OBI_DATA_W-1:0] rd_b_data
);

   logic [OBI_DATA_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_WORDS); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < int'(OBI_BE_W); b++) begin
            if (wr_be[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_a_data = mem[rd_a_idx];
   assign rd_b_data = mem[rd_b_idx];

endmodule

// File: rtl/xheep2bridge_obi_resp.sv
// OBI responder exposing a mailbox to X-HEEP, with a host side port and a sticky doorbell.
module xheep2bridge_obi_resp
   import bridge_pkg::*;
#(
   parameter  int unsigned           NUM_WORDS = 8,
   parameter  logic [OBI_ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   localparam int unsigned           IDX_W     = $clog2(NUM_WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [OBI_BE_W-1:0]   be,
   input  logic [OBI_ADDR_W-1:0] addr,
   input  logic [OBI_DATA_W-1:0] wdata,
   output logic                  gnt,
   output logic                  rvalid,
   output logic [OBI_DATA_W-1:0] rdata,
   output logic                  err,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [IDX_W-1:0]      host_idx,
   input  logic [OBI_DATA_W-1:0] host_wdata,
   output logic [OBI_DATA_W-1:0] host_rdata,
   input  logic                  host_clr_done,
   output logic                  done,
   output logic                  busy
);

   localparam int unsigned          EXT_W    = OBI_ADDR_W + 1;
   localparam logic [EXT_W-1:0]     LO_ADDR  = EXT_W'(BASE_ADDR);
   localparam logic [EXT_W-1:0]     END_ADDR = EXT_W'(BASE_ADDR) + EXT_W'(4 * NUM_WORDS);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);

   resp_state_e           state_q, state_d;
   host_cmd_t             host_cmd_q;
   logic [IDX_W-1:0]      host_idx_q;
   logic                  host_pend_q;
   logic [OBI_DATA_W-1:0] rdata_q;
   logic                  err_q;
   logic [OBI_DATA_W-1:0] host_rdata_q;
   logic                  done_q;

   logic                  gnt_c;
   logic                  host_now_c;
   logic                  host_latch_c;
   logic                  host_defer_c;

   // Address decode; widened compare so the end bound cannot wrap.
   logic [EXT_W-1:0] addr_ext;
   logic             in_range;
   logic [IDX_W-1:0] obi_idx;
   assign addr_ext = {1'b0, addr};
   assign in_range = (addr_ext >= LO_ADDR) && (addr_ext < END_ADDR);
   assign obi_idx  = addr[2 +: IDX_W];

   // Next-state and per-cycle strobes.
   always_comb begin
      state_d      = state_q;
      gnt_c        = 1'b0;
      host_now_c   = 1'b0;
      host_latch_c = 1'b0;
      host_defer_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (host_req) begin
               state_d    = S_HOST;
               host_now_c = 1'b1;
            end else if (req) begin
               gnt_c   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (host_req) begin
               state_d      = S_HOST;
               host_latch_c = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOST: begin
            state_d      = S_IDLE;
            host_defer_c = host_pend_q;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         gnt_c        = 1'b0;
         host_now_c   = 1'b0;
         host_latch_c = 1'b0;
         host_defer_c = 1'b0;
      end
   end

   // Host access uses live inputs when accepted from IDLE, the captured command otherwise.
   logic                  h_do, h_we;
   logic [IDX_W-1:0]      h_idx;
   logic [OBI_DATA_W-1:0] h_wdata;
   logic                  obi_wr;
   assign h_do    = host_now_c | host_defer_c;
   assign h_we    = host_now_c ? host_we    : host_cmd_q.we;
   assign h_idx   = host_now_c ? host_idx   : host_idx_q;
   assign h_wdata = host_now_c ? host_wdata : host_cmd_q.wdata;
   assign obi_wr  = gnt_c & we & in_range;

   logic                  rf_wr_en;
   logic [IDX_W-1:0]      rf_wr_idx;
   logic [OBI_BE_W-1:0]   rf_wr_be;
   logic [OBI_DATA_W-1:0] rf_wr_data;
   logic [OBI_DATA_W-1:0] rd_a_data, rd_b_data;
   assign rf_wr_en   = obi_wr | (h_do & h_we);
   assign rf_wr_idx  = obi_wr ? obi_idx : h_idx;
   assign rf_wr_be   = obi_wr ? be      : '1;
   assign rf_wr_data = obi_wr ? wdata   : h_wdata;

   bridge_mbox_regfile #(
      .NUM_WORDS (NUM_WORDS)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (rf_wr_en),
      .wr_idx    (rf_wr_idx),
      .wr_be     (rf_wr_be),
      .wr_data   (rf_wr_data),
      .rd_a_idx  (obi_idx),
      .rd_a_data (rd_a_data),
      .rd_b_idx  (h_idx),
      .rd_b_data (rd_b_data)
   );

   logic done_set;
   assign done_set = obi_wr && (obi_idx == LAST_IDX) && (|be);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         host_cmd_q   <= '0;
         host_idx_q   <= '0;
         host_pend_q  <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         host_rdata_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         host_pend_q <= host_latch_c;
         if (host_latch_c) begin
            host_cmd_q <= '{we: host_we, wdata: host_wdata};
            host_idx_q <= host_idx;
         end
         rdata_q <= (gnt_c && !we && in_range) ? rd_a_data : '0;
         err_q   <= gnt_c && !in_range;
         if (h_do && !h_we) begin
            host_rdata_q <= rd_b_data;
         end
         // Set has priority over a simultaneous clear.
         done_q <= done_set | (done_q & ~host_clr_done);
      end
   end

   assign gnt        = gnt_c;
   assign rvalid     = (state_q == S_RESP);
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign host_rdata = host_rdata_q;
   assign done       = done_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_xheep2bridge_obi_resp.sv
// Directed self-checking bench for the X-HEEP mailbox OBI responder.
module tb_xheep2bridge_obi_resp;

   localparam logic [31:0] BASE = 32'h2000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic        host_req, host_we;
   logic [2:0]  host_idx;
   logic [31:0] host_wdata, host_rdata;
   logic        host_clr_done, done, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   xheep2bridge_obi_resp #(
      .NUM_WORDS (8),
      .BASE_ADDR (BASE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .we            (we),
      .be            (be),
      .addr          (addr),
      .wdata         (wdata),
      .gnt           (gnt),
      .rvalid        (rvalid),
      .rdata         (rdata),
      .err           (err),
      .host_req      (host_req),
      .host_we       (host_we),
      .host_idx      (host_idx),
      .host_wdata    (host_wdata),
      .host_rdata    (host_rdata),
      .host_clr_done (host_clr_done),
      .done          (done),
      .busy          (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One OBI transaction; bounded wait for grant, returns response data and error.
   task automatic obi_xfer(input logic w, input logic [3:0] b, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] r, output logic e,
                           output int waits);
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      waits = 0;
      #1;
      while (gnt !== 1'b1 && waits < 8) begin
         step();
         waits++;
      end
      chk("obi_gnt", 32'(gnt), 32'd1);
      step();
      req = 1'b0; we = 1'b0;
      chk("obi_rvalid", 32'(rvalid), 32'd1);
      r = rdata;
      e = err;
      step();
      chk("obi_rvalid_one_cycle", 32'(rvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic        e;
      int          w;

      rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = BASE; wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_idx = '0; host_wdata = '0; host_clr_done = 1'b0;
      step(); step();
      chk("rst_gnt_forced", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_host_rdata", host_rdata, 32'd0);
      rst = 1'b0; req = 1'b0;
      step();

      // Host read of word 3 after reset
      host_req = 1'b1; host_we = 1'b0; host_idx = 3'd3;
      #1 chk("host_rd_gnt", 32'(gnt), 32'd0);
      step();
      host_req = 1'b0;
      chk("host_rd_busy", 32'(busy), 32'd1);
      chk("host_rd_w3", host_rdata, 32'd0);
      step();
      chk("host_rd_idle", 32'(busy), 32'd0);

      // Byte-enabled write then read back
      obi_xfer(1'b1, 4'b0101, BASE + 32'd8, 32'hDEAD_BEEF, r, e, w);
      chk("wr_gnt_same_cycle", 32'(w), 32'd0);
      chk("wr_err", 32'(e), 32'd0);
      obi_xfer(1'b0, 4'b0000, BASE + 32'd8, 32'h0, r, e, w);
      chk("rd_w2_be", r, 32'h00AD_00EF);
      chk("rd_w2_err", 32'(e), 32'd0);
      chk("rdata_idle_zero", rdata, 32'd0);

      // Out-of-range accesses
      obi_xfer(1'b0, 4'hF, BASE + 32'd32, 32'h0, r, e, w);
      chk("oor_rd_err", 32'(e), 32'd1);
      chk("oor_rd_data", r, 32'd0);
      obi_xfer(1'b1, 4'hF, BASE + 32'd32, 32'hFFFF_FFFF, r, e, w);
      chk("oor_wr_err", 32'(e), 32'd1);
      obi_xfer(1'b1, 4'hF, BASE - 32'd4, 32'hFFFF_FFFF, r, e, w);
      chk("oor_lo_err", 32'(e), 32'd1);
      chk("oor_lo_no_done", 32'(done), 32'd0);
      obi_xfer(1'b0, 4'hF, BASE, 32'h0, r, e, w);
      chk("oor_no_w0_change", r, 32'd0);
      obi_xfer(1'b0, 4'hF, BASE + 32'd28, 32'h0, r, e, w);
      chk("oor_no_w7_change", r, 32'd0);

      // Doorbell
      req = 1'b1; we = 1'b1; be = 4'b0001; addr = BASE + 32'd28; wdata = 32'h0000_0001;
      #1 chk("db_gnt", 32'(gnt), 32'd1);
      chk("db_done_before", 32'(done), 32'd0);
      step();
      req = 1'b0; we = 1'b0;
      chk("db_done_set", 32'(done), 32'd1);
      step();
      req = 1'b1; we = 1'b1; be = 4'b0010; wdata = 32'h0000_AB00; host_clr_done = 1'b1;
      #1 chk("db2_gnt", 32'(gnt), 32'd1);
      step();
      req = 1'b0; we = 1'b0; host_clr_done = 1'b0;
      chk("db_set_wins", 32'(done), 32'd1);
      step();
      host_clr_done = 1'b1;
      step();
      host_clr_done = 1'b0;
      chk("db_clear", 32'(done), 32'd0);
      obi_xfer(1'b1, 4'b0000, BASE + 32'd28, 32'hFFFF_FFFF, r, e, w);
      chk("be0_err", 32'(e), 32'd0);
      chk("be0_no_done", 32'(done), 32'd0);
      obi_xfer(1'b0, 4'hF, BASE + 32'd28, 32'h0, r, e, w);
      chk("rd_w7", r, 32'h0000_AB01);

      // Host write collides with OBI request
      host_req = 1'b1; host_we = 1'b1; host_idx = 3'd2; host_wdata = 32'h1234_5678;
      req = 1'b1; we = 1'b0; be = 4'hF; addr = BASE + 32'd8;
      #1 chk("host_prio_gnt", 32'(gnt), 32'd0);
      step();
      host_req = 1'b0; host_we = 1'b0;
      chk("host_prio_busy", 32'(busy), 32'd1);
      obi_xfer(1'b0, 4'hF, BASE + 32'd8, 32'h0, r, e, w);
      chk("rd_after_host_wr", r, 32'h1234_5678);

      // Host read accepted during RESP
      req = 1'b1; we = 1'b0; addr = BASE + 32'd8;
      #1 chk("resp_host_gnt", 32'(gnt), 32'd1);
      step();
      req = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_idx = 3'd7;
      chk("resp_host_rvalid", 32'(rvalid), 32'd1);
      step();
      host_req = 1'b0;
      chk("resp_host_busy", 32'(busy), 32'd1);
      step();
      chk("resp_host_rdata", host_rdata, 32'h0000_AB01);
      chk("resp_host_idle", 32'(busy), 32'd0);

      // Back-to-back requests: grant every other cycle
      req = 1'b1; we = 1'b0; addr = BASE + 32'd8;
      for (int i = 0; i < 6; i++) begin
         #1 chk("b2b_gnt", 32'(gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
         @(posedge clk);
      end
      #1 chk("b2b_gnt_again", 32'(gnt), 32'd1);
      step();
      req = 1'b0;
      chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
      rst = 1'b1;
      step();
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();
      obi_xfer(1'b0, 4'hF, BASE + 32'd8, 32'h0, r, e, w);
      chk("midrst_mem_w2", r, 32'd0);
      obi_xfer(1'b0, 4'hF, BASE + 32'd28, 32'h0, r, e, w);
      chk("midrst_mem_w7", r, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
